// File: rtl/alu_serial_addsub.sv
// Multi-cycle add/subtract unit: processes WIDTH-bit operands SLICE bits per clock,
// LSB slice first, with a persistent carry flag for multi-word ADC/SBC chains.
module alu_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("alu_serial_addsub: WIDTH must be >= 2 and a multiple of SLICE");
    end

    // Handshake: start is sampled only while busy=0; done pulses for one cycle
    // on the edge that commits result and flags.
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry_q;

    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_next;
    logic             last;
    logic             accept;

    always_comb begin
        b_eff  = op[0] ? ~b : b;
        // ADD: 0, SUB: 1, ADC/SBC: the flag as committed before this edge
        cin0   = op[1] ? carry_flag : op[0];
        slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry_q};
        acc_next  = (acc >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
        // carry into the MSB is recovered as a ^ b ^ sum at that bit
        ovf_next  = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];
        last      = (cnt == CW'(N - 1));
        accept    = (state == IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            carry_q    <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b1;
            neg_flag   <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_eff;
                carry_q <= cin0;
                cnt     <= '0;
                acc     <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> SLICE;
                b_q     <= b_q >> SLICE;
                carry_q <= slice_sum[SLICE];
                acc     <= acc_next;
                cnt     <= cnt + CW'(1);
                if (last) begin
                    done       <= 1'b1;
                    result     <= acc_next;
                    carry_flag <= slice_sum[SLICE];
                    ovf_flag   <= ovf_next;
                    neg_flag   <= acc_next[WIDTH-1];
                    zero_flag  <= (acc_next == '0);
                end
            end
        end
    end

endmodule

// File: doc/alu_serial_addsub.md
# alu_serial_addsub

Parametrised, multi-cycle add/subtract unit for the bbcpu datapath, the next generation of the combinational N-bit ripple adder. It processes WIDTH-bit operands SLICE bits per clock, LSB slice first, and supports ADD, SUB, ADC and SBC. It keeps a persistent carry flag for multi-word arithmetic. It reports zero, negative, carry and overflow flags, and uses a start/busy/done handshake to the control sequencer.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- SLICE, 2: bits added per cycle; WIDTH must be an integer multiple of SLICE. N = WIDTH/SLICE is the number of slice cycles.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  2  operation select: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
- a  in  WIDTH  first operand; latched on the accepting edge.
- b  in  WIDTH  second operand; latched on the accepting edge.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse when result and flags update.
- result  out  WIDTH  last completed result, held until the next completion.
- carry_flag  out  1  carry out of the MSB of the last completed op.
- zero_flag  out  1  result == 0.
- neg_flag  out  1  result[WIDTH-1].
- ovf_flag  out  1  two's-complement overflow.

## Operation
- States:
  - IDLE: busy=0. On start=1, latch a, b, op and the current carry_flag into the working registers, set slice counter=0 and go to RUN.
  - RUN: busy=1. Each edge adds one SLICE-bit slice with the running carry. The slice sum shifts into the result accumulator from the MSB side. The counter increments.
  - After the Nth slice edge: commit result and flags, pulse done, return to IDLE.
- Effective second operand and carry-in:
  - ADD: b, cin=0.
  - SUB: ~b, cin=1.
  - ADC: b, cin=latched carry_flag.
  - SBC: ~b, cin=latched carry_flag.
- Carry convention: carry=1 means no borrow for SUB/SBC. Full result is a + b_eff + cin, modulo 2^WIDTH.
- carry_flag = carry out of bit WIDTH-1.
- ovf_flag = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- zero_flag and neg_flag are computed from the committed WIDTH-bit result.
- start while busy=1 is ignored; there is no queueing.
- Changes on a, b or op while busy do not affect the operation in flight.
- result and flags change only on the done edge. Intermediate sums are never visible on result.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0.
  - result=0, carry_flag=0, ovf_flag=0, neg_flag=0, zero_flag=1.
  - Working registers are cleared.
- Reset mid-RUN aborts the operation: no done pulse, outputs take reset values.
- start sampled high at edge E0 (IDLE): busy=1 from E0 through E(N-1), i.e. N cycles.
- At edge EN: busy=0, done=1 for exactly one cycle, result and flags valid.
- Latency from the accepting edge to done is N cycles.
- Back-to-back: start high during the done cycle is accepted at that edge (state is IDLE). Sustained throughput is one op per N+1 cycles.
- The ADC/SBC carry-in is carry_flag as it stands at the accepting edge. If the previous op completes on that same edge, the previously committed value is used, not the new one. The sequencer must wait for done before starting a dependent ADC/SBC.
- SLICE=WIDTH (N=1): one RUN cycle; done occurs one cycle after acceptance.

## Test plan
Default parameters WIDTH=8, SLICE=2, N=4, unless stated.
- Reset → result=0x00, zero_flag=1, busy=0, done=0. Then ADD a=0x3C b=0x4A → done exactly 4 cycles after the accepting edge; result=0x86, C=0, V=1, N=1, Z=0; busy high for exactly 4 cycles.
- SUB a=0x10 b=0x10 → result=0x00, Z=1, C=1, V=0. SUB a=0x00 b=0x01 → result=0xFF, C=0, N=1.
- Multi-word chain: ADD 0xFF+0x01 → 0x00, C=1; then ADC 0x00+0x00 → 0x01, C=0. Then SBC 0x05−0x03 with C=0 → 0x01, C=1.
- Ignored start and operand isolation: start ADD 0x01+0x01, then pulse start with a=0xF0 and change a, b and op during busy → only one done; result=0x02. Start asserted in the done cycle → new op accepted; its done arrives 4 cycles later.
- Reset mid-op: assert rst_n=0 two cycles into RUN → busy and done drop immediately, no done pulse after release, result=0x00, zero_flag=1.
- Parameter sweep at WIDTH=16 with SLICE=1 (latency 16), SLICE=4 (latency 4) and SLICE=16 (latency 1): randomized a, b, op compared against an arithmetic model, including ovf on 0x7FFF+0x0001 → 0x8000, V=1.
